// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter_if
//  Purpose  : One master-side memory request/response channel (picorv32
//             native-bus style) into the shared SRAM arbiter.
//  Signals  : valid  - request present, held until ready
//             addr   - byte address
//             wdata  - write data
//             wstrb  - byte strobes, 0 = read, nonzero = write
//             ready  - one-cycle completion pulse
//             rdata  - read data, valid with ready and held afterwards
//  Modports : master (requester side), slave (arbiter side)
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Two-master arbiter/sequencer for a shared single-port SRAM.
//             Master 0 is the CPU bus, master 1 the host (loader/dump) port.
//             Accesses are serialised through IDLE -> ISSUE -> (WAIT) -> ACK,
//             ties are broken round-robin, and host_lock keeps master 0 out.
//  Ports    : clk, nRST         - clock, synchronous active-low reset
//             m0, m1            - master channels (slave modport)
//             host_lock         - blocks new grants to master 0
//             sram_rd_en/wr_en  - SRAM command strobes
//             sram_addr/din/be  - SRAM word address, write data, byte enables
//             sram_dout         - SRAM read data (one cycle after sram_rd_en)
//             busy              - high whenever not IDLE
//             oob_err           - pulse when an out-of-range access completes
//  Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int AW = 10
) (
  input  wire                clk,
  input  wire                nRST,
  sram_port_arbiter_if.slave m0,
  sram_port_arbiter_if.slave m1,
  input  wire                host_lock,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [AW-1:0]      sram_addr,
  output logic [31:0]        sram_din,
  output logic [3:0]         sram_be,
  input  wire  [31:0]        sram_dout,
  output logic               busy,
  output logic               oob_err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_ACK   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        r_gnt;          // 0 = master 0, 1 = master 1
  logic        r_last_grant;
  logic        r_oob;          // out-of-range flag of the access in flight
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_any_req;
  logic        w_pick;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;
  logic        w_sel_write;
  logic        w_sel_oob;
  logic        w_unused_addr_lsb;

  // host_lock only matters here, so it is effectively sampled in IDLE:
  // an already-granted master-0 access runs to completion.
  assign w_elig0   = m0.valid & ~host_lock;
  assign w_elig1   = m1.valid;
  assign w_any_req = w_elig0 | w_elig1;
  // On a tie the master that was not served last wins; a lone requester wins.
  assign w_pick    = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

  // Masters hold their request until ready, so the live inputs of the
  // granted master are stable for the whole transaction.
  assign w_sel_addr  = r_gnt ? m1.addr  : m0.addr;
  assign w_sel_wdata = r_gnt ? m1.wdata : m0.wdata;
  assign w_sel_wstrb = r_gnt ? m1.wstrb : m0.wstrb;
  assign w_sel_write = |w_sel_wstrb;
  assign w_sel_oob   = |w_sel_addr[31:AW+2];
  // Byte-lane bits of the address carry no meaning for a word SRAM.
  assign w_unused_addr_lsb = ^w_sel_addr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_any_req) w_next_state = c_ISSUE;
      c_ISSUE: w_next_state = w_sel_write ? c_ACK : c_WAIT;
      c_WAIT:  w_next_state = c_ACK;
      c_ACK:   w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Grant bookkeeping and read-data capture
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_oob        <= 1'b0;
      r_m0_rdata   <= 32'h0;
      r_m1_rdata   <= 32'h0;
    end else begin
      if ((r_state == c_IDLE) && w_any_req) begin
        r_gnt        <= w_pick;
        r_last_grant <= w_pick;
      end
      if (r_state == c_ISSUE) begin
        r_oob <= w_sel_oob;
      end
      // An out-of-range read never touched the SRAM, so it returns zero.
      if (r_state == c_WAIT) begin
        if (r_gnt) begin
          r_m1_rdata <= r_oob ? 32'h0 : sram_dout;
        end else begin
          r_m0_rdata <= r_oob ? 32'h0 : sram_dout;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    sram_addr  = '0;
    sram_din   = 32'h0;
    sram_be    = 4'h0;
    m0.ready   = 1'b0;
    m1.ready   = 1'b0;
    oob_err    = 1'b0;
    busy       = (r_state != c_IDLE);
    case (r_state)
      c_ISSUE: begin
        sram_addr  = w_sel_addr[AW+1:2];
        sram_din   = w_sel_wdata;
        sram_be    = w_sel_write ? w_sel_wstrb : 4'b1111;
        sram_wr_en = w_sel_write & ~w_sel_oob;
        sram_rd_en = ~w_sel_write & ~w_sel_oob;
      end
      c_ACK: begin
        m0.ready = ~r_gnt;
        m1.ready = r_gnt;
        oob_err  = r_oob;
      end
      default: begin
      end
    endcase
  end

  assign m0.rdata = r_m0_rdata;
  assign m1.rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Self-checking bench for sram_port_arbiter: directed vector
//             table, hand-written arbitration/lock/reset sequences, and a
//             randomised two-master run against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          host_lock = 1'b0;
  logic          sram_rd_en, sram_wr_en;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_din;
  logic [3:0]    sram_be;
  logic [31:0]   sram_dout = 32'h0;
  logic          busy, oob_err;

  sram_port_arbiter_if m0_if();
  sram_port_arbiter_if m1_if();

  sram_port_arbiter #(.AW(AW)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .m0         (m0_if),
    .m1         (m1_if),
    .host_lock  (host_lock),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_be    (sram_be),
    .sram_dout  (sram_dout),
    .busy       (busy),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // SRAM model: one-cycle read latency, byte-enabled writes, preloaded once.
  logic [31:0] mem [0:1023];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + i;
      loaded <= 1'b1;
    end else begin
      if (sram_rd_en) sram_dout <= mem[sram_addr];
      if (sram_wr_en) mem[sram_addr] <= merge(mem[sram_addr], sram_din, sram_be);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin
      m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
    end else begin
      m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_if.ready : m1_if.ready;
  endfunction

  function automatic logic [31:0] rdt(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  task automatic reset_dut();
    nRST = 1'b0;
    host_lock = 1'b0;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask

  // One isolated transaction started in an IDLE cycle; reports latency in
  // cycles from the request cycle to the ready cycle.
  task automatic do_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat,
                        output int oob_cnt, output int strobe_cnt, output bit done);
    drive(m, 1'b1, a, d, s);
    lat = 0; oob_cnt = 0; strobe_cnt = 0; done = 1'b0; rd = 32'h0;
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (sram_rd_en || sram_wr_en) strobe_cnt++;
      if (oob_err) oob_cnt++;
      if (rdy(m)) begin lat = i; rd = rdt(m); done = 1'b1; end
    end
    drive(m, 1'b0, a, d, s);
    @(negedge clk);
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rd;
    int          oob;
  } vec_t;

  vec_t vecs[9];

  // Random-phase model state
  logic [31:0] shadow [0:1023];
  bit          pend[2], gr[2], er_now[2];
  int          rc[2];
  logic [31:0] pa[2], pd[2], er[2], vis[2];
  logic [3:0]  ps[2];
  int          g_cyc, busy_end, lg, w, got, cnt0, cnt1;
  bit          cur_wr, cur_oob, lock, e0, e1, done, first_m0, seen;
  logic [AW-1:0] cur_idx;
  logic [3:0]  cur_be;
  logic [31:0] cur_din, rd;
  int          lat, oc, sc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 0};
    vecs[1] = '{0, 32'h0000_0010, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1, 32'h0000_0020, 32'h1122_3344, 4'hF, 2, 32'h0, 0};
    vecs[3] = '{1, 32'h0000_0020, 32'hAAAA_AAAA, 4'h4, 2, 32'h0, 0};
    vecs[4] = '{1, 32'h0000_0020, 32'h0,         4'h0, 3, 32'h11AA_3344, 0};
    vecs[5] = '{0, 32'h0000_1000, 32'h0,         4'h0, 3, 32'h0, 1};
    vecs[6] = '{0, 32'h0000_1010, 32'h5555_5555, 4'hF, 2, 32'h0, 1};
    vecs[7] = '{0, 32'h0000_0013, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 0};
    vecs[8] = '{1, 32'h0000_0022, 32'h0,         4'h0, 3, 32'h11AA_3344, 0};

    // ---------------- reset state ----------------
    reset_dut();
    chkb("rst_m0_ready", m0_if.ready, 1'b0);
    chkb("rst_m1_ready", m1_if.ready, 1'b0);
    chk ("rst_m0_rdata", m0_if.rdata, 32'h0);
    chk ("rst_m1_rdata", m1_if.rdata, 32'h0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_oob", oob_err, 1'b0);
    chkb("rst_rd_en", sram_rd_en, 1'b0);
    chkb("rst_wr_en", sram_wr_en, 1'b0);
    chk ("rst_sram_bus", {22'h0, sram_addr, sram_be, sram_din[3:0]} | sram_din, 32'h0);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat, oc, sc, done);
      chkb($sformatf("v%0d_done", i), done, 1'b1);
      chk ($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk ($sformatf("v%0d_oob_pulses", i), oc, vecs[i].oob);
      chk ($sformatf("v%0d_sram_strobes", i), sc, (vecs[i].oob != 0) ? 0 : 1);
      if (vecs[i].wstrb == 4'h0) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rd);
    end

    // ---------------- contention after reset ----------------
    reset_dut();
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h80, 32'h0, 4'h0);
    got = 0;
    for (int n = 0; n < 40 && got < 4; n++) begin
      @(negedge clk);
      if (m0_if.ready) begin
        chkb("cont_order_m0", (got % 2) == 0, 1'b1);
        chk ("cont_m0_rdata", m0_if.rdata, 32'hC0DE_0010);
        got++;
      end
      if (m1_if.ready) begin
        chkb("cont_order_m1", (got % 2) == 1, 1'b1);
        chk ("cont_m1_rdata", m1_if.rdata, 32'hC0DE_0020);
        got++;
      end
    end
    chk("cont_grants", got, 4);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);

    // ---------------- host lock ----------------
    host_lock = 1'b1;
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h80, 32'h0, 4'h0);
    cnt0 = 0; cnt1 = 0;
    repeat (20) begin
      @(negedge clk);
      if (m0_if.ready) cnt0++;
      if (m1_if.ready) cnt1++;
    end
    chk ("lock_m0_served", cnt0, 0);
    chkb("lock_m1_served", cnt1 >= 3, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (m1_if.ready) seen = 1'b1;
    end
    chkb("lock_m1_ack_seen", seen, 1'b1);
    host_lock = 1'b0;
    seen = 1'b0; first_m0 = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (m0_if.ready || m1_if.ready) begin seen = 1'b1; first_m0 = m0_if.ready; end
    end
    chkb("unlock_ack_seen", seen, 1'b1);
    chkb("unlock_grants_m0", first_m0, 1'b1);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);

    // ---------------- reset during WAIT ----------------
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    chkb("rstw_issue_rd_en", sram_rd_en, 1'b1);
    @(negedge clk);
    chkb("rstw_wait_busy", busy, 1'b1);
    nRST = 1'b0;
    @(negedge clk);
    chkb("rstw_busy", busy, 1'b0);
    chkb("rstw_m0_ready", m0_if.ready, 1'b0);
    chk ("rstw_m0_rdata", m0_if.rdata, 32'h0);
    nRST = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    cnt0 = 0;
    repeat (5) begin
      @(negedge clk);
      if (m0_if.ready) cnt0++;
    end
    chk("rstw_no_late_ready", cnt0, 0);
    drive(0, 1'b1, 32'h40, 32'h0, 4'h0);
    drive(1, 1'b1, 32'h80, 32'h0, 4'h0);
    seen = 1'b0; first_m0 = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (m0_if.ready || m1_if.ready) begin seen = 1'b1; first_m0 = m0_if.ready; end
    end
    chkb("rstw_tie_seen", seen, 1'b1);
    chkb("rstw_tie_m0", first_m0, 1'b1);

    // ---------------- randomised run vs transaction model ----------------
    reset_dut();
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; gr[k] = 1'b0; rc[k] = -1; vis[k] = 32'h0; er[k] = 32'h0;
      pa[k] = 32'h0; pd[k] = 32'h0; ps[k] = 4'h0;
    end
    g_cyc = -10; busy_end = -1; lg = 1; lock = 1'b0;
    cur_wr = 1'b0; cur_oob = 1'b0; cur_idx = '0; cur_be = 4'h0; cur_din = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      // compare this cycle's outputs with the model
      for (int k = 0; k < 2; k++) begin
        er_now[k] = pend[k] && gr[k] && (rc[k] == c);
        if (er_now[k] && ps[k] == 4'h0) vis[k] = er[k];
        chkb($sformatf("rnd_m%0d_ready c%0d", k, c), rdy(k), er_now[k]);
        chk ($sformatf("rnd_m%0d_rdata c%0d", k, c), rdt(k), vis[k]);
      end
      chkb($sformatf("rnd_busy c%0d", c), busy, (c > g_cyc) && (c <= busy_end));
      chkb($sformatf("rnd_oob c%0d", c), oob_err, (c == busy_end) && cur_oob);
      chkb($sformatf("rnd_rd_en c%0d", c), sram_rd_en, (c == g_cyc + 1) && !cur_wr && !cur_oob);
      chkb($sformatf("rnd_wr_en c%0d", c), sram_wr_en, (c == g_cyc + 1) && cur_wr && !cur_oob);
      if ((c == g_cyc + 1) && !cur_oob) begin
        chk($sformatf("rnd_sram_addr c%0d", c), {22'h0, sram_addr}, {22'h0, cur_idx});
        chk($sformatf("rnd_sram_be c%0d", c), {28'h0, sram_be}, {28'h0, cur_be});
        if (cur_wr) chk($sformatf("rnd_sram_din c%0d", c), sram_din, cur_din);
      end
      // masters: retire completed requests, maybe issue new ones
      for (int k = 0; k < 2; k++) begin
        if (er_now[k]) begin pend[k] = 1'b0; gr[k] = 1'b0; end
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          if ($urandom_range(0, 7) == 0) pa[k] = $urandom | 32'h0000_1000;
          else pa[k] = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
          pd[k] = $urandom;
          ps[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        end
        drive(k, pend[k], pa[k], pd[k], ps[k]);
      end
      if ($urandom_range(0, 15) == 0) lock = ~lock;
      host_lock = lock;
      // arbitration: a new access starts only once the previous one is acked
      if (c > busy_end) begin
        e0 = pend[0] && !lock;
        e1 = pend[1];
        if (e0 || e1) begin
          w = (e0 && e1) ? ((lg == 1) ? 0 : 1) : (e0 ? 0 : 1);
          lg = w;
          g_cyc = c;
          cur_wr = (ps[w] != 4'h0);
          cur_oob = (pa[w][31:12] != 20'h0);
          cur_idx = pa[w][11:2];
          cur_be = cur_wr ? ps[w] : 4'hF;
          cur_din = pd[w];
          busy_end = c + (cur_wr ? 2 : 3);
          er[w] = cur_oob ? 32'h0 : shadow[cur_idx];
          if (cur_wr && !cur_oob) shadow[cur_idx] = merge(shadow[cur_idx], pd[w], ps[w]);
          gr[w] = 1'b1;
          rc[w] = busy_end;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-master arbiter and sequencer for the shared 1K×32 single-port SRAM. Master 0 is the picorv32 native memory bus; master 1 is the host port used by the UART loader and the memory-dump path. The block serialises accesses, applies SRAM read latency, returns read data and one-cycle ready pulses, and lets the host lock the core out during program load.

## Interface
- AW, 10, SRAM word-address width; byte addresses use bits [AW+1:2].
- clk  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- m0_valid / m1_valid  in  1  request present; held until the matching ready.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read, nonzero = write.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data, valid while ready is high and held afterwards.
- host_lock  in  1  when 1, master 0 is never granted.
- sram_rd_en, sram_wr_en  out  1  SRAM command strobes.
- sram_addr  out  AW  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_be  out  4  SRAM byte enables.
- sram_dout  in  32  SRAM read data, valid the cycle after sram_rd_en.
- busy  out  1  high in every state except IDLE.
- oob_err  out  1  one-cycle pulse when an out-of-range access completes.

## Operation
- Reset values: both ready outputs 0, both rdata outputs 32'h0, busy 0, oob_err 0, all sram_* outputs 0, state IDLE, last_grant = 1.
- The FSM has four states: IDLE, ISSUE, WAIT and ACK.
- IDLE: eligible requesters are m1_valid and (m0_valid & ~host_lock).
  - If only one is eligible, it is granted.
  - If both are eligible, the master other than last_grant wins (round-robin). After reset, master 0 wins the first tie.
  - On a grant, register gnt, update last_grant, and go to ISSUE.
- ISSUE: drive the SRAM from the granted master's live inputs: sram_addr = addr[AW+1:2], sram_din = wdata, sram_be = wstrb (4'b1111 for a read).
  - A write asserts sram_wr_en and goes to ACK.
  - A read asserts sram_rd_en and goes to WAIT.
- WAIT: capture sram_dout into the granted master's rdata register, then go to ACK.
- ACK: the granted master's ready is 1 for exactly this cycle. Go to IDLE.
- All sram_* outputs are 0 outside ISSUE. The non-granted master's ready and rdata are untouched.
- Out of range means addr[31:AW+2] != 0. For such an access, ISSUE asserts no SRAM strobe.
  - A read returns 32'h0 with the normal read latency.
  - A write is dropped but still acked with the normal write latency.
  - oob_err pulses in the ACK cycle.
- Address bits [1:0] are ignored.
- host_lock is sampled only in IDLE. Asserting it mid-transaction does not abort a master-0 access already granted.

## Timing
- A request is seen in IDLE at cycle T.
- Write: SRAM write at the end of T+1; ready at T+2. Throughput is one write per 3 cycles per master.
- Read: sram_rd_en at T+1; capture at T+2; ready and rdata at T+3.
- A master that drops valid the cycle after ready (picorv32 behaviour) is never double-served, because IDLE samples it at T+3 (write) or T+4 (read).
- A master may present a new request in the cycle after ACK. It is arbitrated in that IDLE cycle.
- When both masters are continuously valid, grants alternate strictly: 0,1,0,1…
- If valid drops before ready, behaviour is undefined. Masters must hold.
- If nRST is low in any cycle, all of the following happen at the next edge:
  - the transaction is aborted;
  - the outputs take their reset values;
  - no ready is issued for the aborted access.

## Test plan
- Single write, then read by m0: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF. ready comes at T+2. A read of 0x10 gives ready at T+3 with rdata 0xDEADBEEF.
- Byte strobe: with word 0x11223344 at 0x20, m1 writes wstrb 4'b0100, wdata 0xAAAAAAAA. A readback gives 0x11AA3344.
- Contention: both valid continuously with reads of distinct preloaded words. Grant order after reset is m0, m1, m0, m1, and each rdata matches its own address.
- host_lock=1 with both valid: only m1 is served. Releasing the lock grants m0 on the next IDLE.
- Out of range: m0 reads 0x00001000 with AW=10. There is no sram_rd_en, rdata is 0, ready comes at T+3, and oob_err pulses once. An out-of-range write leaves SRAM unchanged.
- Reset mid-read: pull nRST low during WAIT. No ready is issued, busy is 0, and the next tie is granted to m0.
